timer_counter_irq: RTL and testbench

//  64-bit free-running system timer with prescaler, debug halt and compare interrupt.

---
 rtl/timer_counter_irq.sv | 138 +++++++++++++
 tb/tb_timer_counter_irq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_irq.sv
// 64-bit free-running system timer with a power-of-two prescaler, debug halt and a
// compare interrupt; also owns the read mux for the whole timer register window.
module timer_counter_irq #(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter logic [3:0]  DIV_MAX   = 4'd8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [63:0] tcmp,
   input  logic        dbg_mode,
   output logic [31:0] rdata,
   output logic [63:0] cnt,
   output logic        irq,
   output logic        halt_ack
);

   localparam logic [31:0] A_TCR   = BASE_ADDR + 32'h00;
   localparam logic [31:0] A_TDR0  = BASE_ADDR + 32'h04;
   localparam logic [31:0] A_TDR1  = BASE_ADDR + 32'h08;
   localparam logic [31:0] A_TCMP0 = BASE_ADDR + 32'h0C;
   localparam logic [31:0] A_TCMP1 = BASE_ADDR + 32'h10;
   localparam logic [31:0] A_TIER  = BASE_ADDR + 32'h14;
   localparam logic [31:0] A_TISR  = BASE_ADDR + 32'h18;
   localparam logic [31:0] A_THCSR = BASE_ADDR + 32'h1C;

   logic        timer_en_q, timer_en_d;
   logic        div_en_q, div_en_d;
   logic [3:0]  div_val_q, div_val_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic [63:0] cnt_q, cnt_d;
   logic        int_en_q, int_en_d;
   logic        int_st_q, int_st_d;
   logic        halt_req_q, halt_req_d;
   logic        halt_ack_q, halt_ack_d;

   logic        wr_tcr, wr_tdr0, wr_tdr1, wr_tier, wr_tisr, wr_thcsr;
   logic        tcr_ok, halt, tick, match;
   logic [7:0]  pcnt_last;

   assign wr_tcr   = wr_en & (addr == A_TCR);
   assign wr_tdr0  = wr_en & (addr == A_TDR0);
   assign wr_tdr1  = wr_en & (addr == A_TDR1);
   assign wr_tier  = wr_en & (addr == A_TIER);
   assign wr_tisr  = wr_en & (addr == A_TISR);
   assign wr_thcsr = wr_en & (addr == A_THCSR);

   // An out-of-range divider request rejects the entire TCR write, including the enable bit.
   assign tcr_ok    = wr_tcr & (wdata[11:8] <= DIV_MAX);
   assign halt      = dbg_mode & halt_req_q;
   assign pcnt_last = 8'hFF >> (4'd8 - div_val_q);
   assign tick      = timer_en_q & ~halt & (~div_en_q | (pcnt_q == pcnt_last));
   assign match     = (cnt_q == tcmp);

   always_comb begin
      timer_en_d = timer_en_q;
      div_en_d   = div_en_q;
      div_val_d  = div_val_q;
      pcnt_d     = pcnt_q;
      cnt_d      = cnt_q;
      int_en_d   = int_en_q;
      int_st_d   = int_st_q;
      halt_req_d = halt_req_q;
      halt_ack_d = halt;

      if (tcr_ok) begin
         timer_en_d = wdata[0];
         if (!timer_en_q) begin
            div_en_d  = wdata[1];
            div_val_d = wdata[11:8];
         end
      end

      if (!timer_en_q || !div_en_q) pcnt_d = 8'd0;
      else if (halt)                pcnt_d = pcnt_q;
      else if (tick)                pcnt_d = 8'd0;
      else                          pcnt_d = pcnt_q + 8'd1;

      // A bus load of either half takes priority over the tick and never carries.
      if (wr_tdr0)      cnt_d[31:0]  = wdata;
      else if (wr_tdr1) cnt_d[63:32] = wdata;
      else if (tick)    cnt_d        = cnt_q + 64'd1;

      if (wr_tier)  int_en_d   = wdata[0];
      if (wr_thcsr) halt_req_d = wdata[0];

      int_st_d = match | (int_st_q & ~(wr_tisr & wdata[0]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_en_q <= 1'b0;
         div_en_q   <= 1'b0;
         div_val_q  <= 4'd1;
         pcnt_q     <= 8'd0;
         cnt_q      <= 64'd0;
         int_en_q   <= 1'b0;
         int_st_q   <= 1'b0;
         halt_req_q <= 1'b0;
         halt_ack_q <= 1'b0;
      end else begin
         timer_en_q <= timer_en_d;
         div_en_q   <= div_en_d;
         div_val_q  <= div_val_d;
         pcnt_q     <= pcnt_d;
         cnt_q      <= cnt_d;
         int_en_q   <= int_en_d;
         int_st_q   <= int_st_d;
         halt_req_q <= halt_req_d;
         halt_ack_q <= halt_ack_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (rd_en) begin
         case (addr)
            A_TCR:   rdata = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
            A_TDR0:  rdata = cnt_q[31:0];
            A_TDR1:  rdata = cnt_q[63:32];
            A_TCMP0: rdata = tcmp[31:0];
            A_TCMP1: rdata = tcmp[63:32];
            A_TIER:  rdata = {31'd0, int_en_q};
            A_TISR:  rdata = {31'd0, int_st_q};
            A_THCSR: rdata = {30'd0, halt_ack_q, halt_req_q};
            default: rdata = 32'd0;
         endcase
      end
   end

   assign cnt      = cnt_q;
   assign irq      = int_st_q & int_en_q;
   assign halt_ack = halt_ack_q;

endmodule

// File: tb/tb_timer_counter_irq.sv
// Bench for timer_counter_irq: directed scenarios plus randomized bus/debug traffic
// checked against a cycle-level behavioural model of the timer.
module tb_timer_counter_irq;

   localparam logic [31:0] BASE    = 32'h2000_0000;
   localparam logic [31:0] A_TCR   = BASE + 32'h00;
   localparam logic [31:0] A_TDR0  = BASE + 32'h04;
   localparam logic [31:0] A_TDR1  = BASE + 32'h08;
   localparam logic [31:0] A_TCMP0 = BASE + 32'h0C;
   localparam logic [31:0] A_TCMP1 = BASE + 32'h10;
   localparam logic [31:0] A_TIER  = BASE + 32'h14;
   localparam logic [31:0] A_TISR  = BASE + 32'h18;
   localparam logic [31:0] A_THCSR = BASE + 32'h1C;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata;
   logic        wr_en, rd_en;
   logic [63:0] tcmp;
   logic        dbg_mode;
   logic [31:0] rdata;
   logic [63:0] cnt;
   logic        irq, halt_ack;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [63:0] m_cnt;
   bit          m_en, m_den, m_ien, m_st, m_hreq, m_hack;
   int          m_dval, m_phase;

   timer_counter_irq #(.BASE_ADDR(BASE), .DIV_MAX(4'd8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en), .rd_en(rd_en),
      .tcmp(tcmp), .dbg_mode(dbg_mode), .rdata(rdata), .cnt(cnt), .irq(irq),
      .halt_ack(halt_ack)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_cnt = 64'd0; m_en = 0; m_den = 0; m_dval = 1; m_phase = 0;
      m_ien = 0; m_st = 0; m_hreq = 0; m_hack = 0;
   endtask

   function automatic logic [31:0] exp_rdata();
      if (!rd_en) return 32'd0;
      case (addr)
         A_TCR:   return 32'((m_dval << 8) + (int'(m_den) << 1) + int'(m_en));
         A_TDR0:  return m_cnt[31:0];
         A_TDR1:  return m_cnt[63:32];
         A_TCMP0: return tcmp[31:0];
         A_TCMP1: return tcmp[63:32];
         A_TIER:  return 32'(m_ien);
         A_TISR:  return 32'(m_st);
         A_THCSR: return 32'(int'(m_hreq) + 2 * int'(m_hack));
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model by one clock using the inputs as currently driven, then clock the DUT.
   task automatic step();
      bit halt, tick, n_en, n_den, n_st, n_ien, n_hreq;
      int period, n_phase, n_dval;
      logic [63:0] n_cnt;
      halt   = dbg_mode && m_hreq;
      period = 1 << m_dval;
      tick   = m_en && !halt && (!m_den || m_phase == period - 1);
      if (!m_en || !m_den) n_phase = 0;
      else if (halt)       n_phase = m_phase;
      else                 n_phase = (m_phase + 1) % period;
      n_cnt = m_cnt;
      if (wr_en && addr == A_TDR0)      n_cnt[31:0]  = wdata;
      else if (wr_en && addr == A_TDR1) n_cnt[63:32] = wdata;
      else if (tick)                    n_cnt        = m_cnt + 64'd1;
      n_en = m_en; n_den = m_den; n_dval = m_dval;
      if (wr_en && addr == A_TCR && int'(wdata[11:8]) <= 8) begin
         n_en = wdata[0];
         if (!m_en) begin
            n_den  = wdata[1];
            n_dval = int'(wdata[11:8]);
         end
      end
      n_ien  = (wr_en && addr == A_TIER)  ? wdata[0] : m_ien;
      n_hreq = (wr_en && addr == A_THCSR) ? wdata[0] : m_hreq;
      n_st   = (m_cnt == tcmp) || (m_st && !(wr_en && addr == A_TISR && wdata[0]));
      @(posedge clk);
      #1;
      m_cnt = n_cnt; m_en = n_en; m_den = n_den; m_dval = n_dval; m_phase = n_phase;
      m_ien = n_ien; m_hreq = n_hreq; m_st = n_st; m_hack = halt;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; dbg_mode = 1'b0; tcmp = '1;
      model_reset();
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_en = 1'b1; addr = A_TCR;
      #1;
      total++; if (cnt !== 64'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", cnt); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
      total++; if (halt_ack !== 1'b0) begin bad++; $display("FAIL reset_hack: got %b want 0", halt_ack); end
      total++; if (rdata !== 32'h0000_0100) begin bad++; $display("FAIL reset_tcr: got %h want 00000100", rdata); end
      addr = A_TISR;
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_tisr: got %h want 0", rdata); end
      rd_en = 1'b0;
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      do_reset();
      bus_wr(A_TCR, 32'h1);
      total++; if (cnt !== 64'd0) begin bad++; $display("FAIL t1_start: got %h want 0", cnt); end
      rd_en = 1'b1; addr = A_TDR0;
      for (int i = 1; i <= 3; i++) begin
         #2;
         total++; if (rdata !== 32'(i - 1)) begin bad++; $display("FAIL t1_rd: got %h want %h", rdata, 32'(i - 1)); end
         step();
         total++; if (cnt !== 64'(i)) begin bad++; $display("FAIL t1_cnt: got %h want %h", cnt, 64'(i)); end
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL t1_irq: got %b want 0", irq); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_prescale();
      do_reset();
      bus_wr(A_TCR, 32'h203);
      for (int k = 1; k <= 12; k++) begin
         step();
         total++; if (cnt !== 64'(k / 4)) begin bad++; $display("FAIL t2_div4: got %h want %h", cnt, 64'(k / 4)); end
      end
      bus_wr(A_TCR, 32'h903);
      rd_en = 1'b1; addr = A_TCR;
      #1;
      total++; if (rdata !== 32'h203) begin bad++; $display("FAIL t2_bigdiv: got %h want 00000203", rdata); end
      rd_en = 1'b0;
      bus_wr(A_TCR, 32'h200);
      rd_en = 1'b1; addr = A_TCR;
      #1;
      total++; if (rdata !== 32'h202) begin bad++; $display("FAIL t2_protect: got %h want 00000202", rdata); end
      rd_en = 1'b0;
      for (int k = 0; k < 6; k++) step();
      total++; if (cnt !== m_cnt) begin bad++; $display("FAIL t2_frozen: got %h want %h", cnt, m_cnt); end
   endtask

   task automatic test_carry_irq();
      do_reset();
      tcmp = 64'h1_0000_0000;
      bus_wr(A_TDR1, 32'h0);
      bus_wr(A_TDR0, 32'hFFFF_FFFE);
      bus_wr(A_TIER, 32'h1);
      bus_wr(A_TCR, 32'h1);
      step();
      total++; if (cnt !== 64'h0000_0000_FFFF_FFFF) begin bad++; $display("FAIL t3_tick1: got %h want 00000000ffffffff", cnt); end
      step();
      total++; if (cnt !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL t3_carry: got %h want 0000000100000000", cnt); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL t3_irq_early: got %b want 0", irq); end
      step();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL t3_irq: got %b want 1", irq); end
      bus_wr(A_TISR, 32'h1);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL t3_clear: got %b want 0", irq); end
   endtask

   task automatic test_wrap();
      do_reset();
      bus_wr(A_TDR0, 32'hFFFF_FFFF);
      bus_wr(A_TDR1, 32'hFFFF_FFFF);
      bus_wr(A_TCR, 32'h1);
      step();
      total++; if (cnt !== 64'd0) begin bad++; $display("FAIL t4_wrap: got %h want 0", cnt); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL t4_irq: got %b want 0", irq); end
      bus_wr(A_TDR0, 32'h1234_5678);
      total++; if (cnt !== 64'h0000_0000_1234_5678) begin bad++; $display("FAIL t4_load: got %h want 0000000012345678", cnt); end
      step();
      total++; if (cnt !== 64'h0000_0000_1234_5679) begin bad++; $display("FAIL t4_after: got %h want 0000000012345679", cnt); end
   endtask

   task automatic test_halt();
      do_reset();
      bus_wr(A_TCR, 32'h1);
      for (int k = 0; k < 3; k++) step();
      bus_wr(A_THCSR, 32'h1);
      total++; if (cnt !== 64'd4) begin bad++; $display("FAIL t5_pre: got %h want 4", cnt); end
      dbg_mode = 1'b1;
      #2;
      total++; if (halt_ack !== 1'b0) begin bad++; $display("FAIL t5_lag: got %b want 0", halt_ack); end
      for (int k = 0; k < 5; k++) begin
         step();
         total++; if (cnt !== 64'd4) begin bad++; $display("FAIL t5_frozen: got %h want 4", cnt); end
         total++; if (halt_ack !== 1'b1) begin bad++; $display("FAIL t5_ack: got %b want 1", halt_ack); end
      end
      rd_en = 1'b1; addr = A_THCSR;
      #1;
      total++; if (rdata !== 32'h3) begin bad++; $display("FAIL t5_thcsr: got %h want 3", rdata); end
      rd_en = 1'b0;
      dbg_mode = 1'b0;
      #1;
      total++; if (halt_ack !== 1'b1) begin bad++; $display("FAIL t5_ack_hold: got %b want 1", halt_ack); end
      step();
      total++; if (cnt !== 64'd5) begin bad++; $display("FAIL t5_resume: got %h want 5", cnt); end
      total++; if (halt_ack !== 1'b0) begin bad++; $display("FAIL t5_ack_drop: got %b want 0", halt_ack); end
      step();
      total++; if (cnt !== 64'd6) begin bad++; $display("FAIL t5_resume2: got %h want 6", cnt); end
   endtask

   task automatic test_race_and_async_reset();
      do_reset();
      bus_wr(A_TDR0, 32'd5);
      tcmp = 64'd5;
      bus_wr(A_TIER, 32'h1);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL t6_set: got %b want 1", irq); end
      bus_wr(A_TISR, 32'h1);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL t6_set_wins: got %b want 1", irq); end
      tcmp = 64'd7;
      bus_wr(A_TISR, 32'h1);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL t6_clear: got %b want 0", irq); end
      bus_wr(A_TCR, 32'h1);
      for (int k = 0; k < 3; k++) step();
      total++; if (cnt !== 64'd8) begin bad++; $display("FAIL t6_cnt: got %h want 8", cnt); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL t6_match: got %b want 1", irq); end
      rst = 1'b1; rd_en = 1'b1; addr = A_TCR;
      #1;
      total++; if (cnt !== 64'd0) begin bad++; $display("FAIL t6_rst_cnt: got %h want 0", cnt); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL t6_rst_irq: got %b want 0", irq); end
      total++; if (rdata !== 32'h100) begin bad++; $display("FAIL t6_rst_tcr: got %h want 00000100", rdata); end
      rd_en = 1'b0;
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         wr_en = ($urandom_range(0, 3) == 0);
         rd_en = $urandom_range(0, 1);
         a = BASE + 32'(4 * $urandom_range(0, 8));
         addr = a;
         case (a)
            A_TCR:   wdata = 32'(($urandom_range(0, 10) << 8) | ($urandom & 3));
            A_TDR0, A_TDR1, A_TCMP0, A_TCMP1: wdata = $urandom;
            default: wdata = $urandom & 32'h3;
         endcase
         if ($urandom_range(0, 5) == 0) dbg_mode = ~dbg_mode;
         if ($urandom_range(0, 7) == 0) tcmp = m_cnt + 64'($urandom_range(0, 5));
         #2;
         total++; if (rdata !== exp_rdata()) begin bad++; $display("FAIL rnd_rdata: got %h want %h addr %h", rdata, exp_rdata(), addr); end
         step();
         total++; if (cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt: got %h want %h", cnt, m_cnt); end
         total++; if (irq !== (m_st & m_ien)) begin bad++; $display("FAIL rnd_irq: got %b want %b", irq, m_st & m_ien); end
         total++; if (halt_ack !== m_hack) begin bad++; $display("FAIL rnd_hack: got %b want %b", halt_ack, m_hack); end
      end
      wr_en = 1'b0; rd_en = 1'b0; dbg_mode = 1'b0;
   endtask

   initial begin
      rst = 1'b1; addr = A_TCR; wdata = 32'd0; wr_en = 1'b0; rd_en = 1'b0;
      tcmp = '1; dbg_mode = 1'b0;
      model_reset();
      test_reset();
      test_free_run();
      test_prescale();
      test_carry_irq();
      test_wrap();
      test_halt();
      test_race_and_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
